systolic_mm_engine: RTL and testbench

Parametrised output-stationary systolic engine computing C = A x B, where A is ROWS x K, B is K x COLS and K is chosen per job at runtime. It generalises the fixed n x n array to rectangular geometry, configurable data and accumulator widths, and internal input skewing. It adds valid/ready streaming of operands and results, plus a job FSM with fill, flush and drain phases. It sits between the operand fetch logic and the result write-back path.

---
 rtl/systolic_pkg.sv | 37 +++
 rtl/systolic_pe.sv | 89 ++++++++
 rtl/systolic_mm_engine.sv | 204 ++++++++++++++++++++
 tb/tb_systolic_mm_engine.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/systolic_pkg.sv
// Shared FSM encoding and arithmetic helpers for the systolic matrix-multiply engine.
// Optional build macro SYSTOLIC_SAT_EN selects saturating accumulation.
package systolic_pkg;

  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_LOAD  = 2'd1;
  localparam state_t ST_FLUSH = 2'd2;
  localparam state_t ST_DRAIN = 2'd3;

  // Helpers work at one wide width; callers keep their own widths below it.
  localparam int MAX_W = 64;
  typedef logic signed [MAX_W-1:0] wide_t;

  function automatic int flush_len(input int rows, input int cols);
    return rows + cols - 2;
  endfunction

  function automatic wide_t sext(input wide_t v, input int w);
    return (v <<< (MAX_W - w)) >>> (MAX_W - w);
  endfunction

  function automatic wide_t sat_add(input wide_t a, input wide_t b, input int w);
    wide_t sum;
    wide_t hi;
    wide_t lo;
    wide_t res;
    sum = a + b;
    hi  = (wide_t'(1) <<< (w - 1)) - wide_t'(1);
    lo  = -hi - wide_t'(1);
    if (sum > hi)      res = hi;
    else if (sum < lo) res = lo;
    else               res = sum;
    return res;
  endfunction

endpackage

// File: rtl/systolic_pe.sv
// One output-stationary processing element: operand pass-through plus MAC accumulator.
// With SYSTOLIC_SAT_EN defined the accumulator saturates and keeps a sticky overflow flag.
module systolic_pe
  import systolic_pkg::*;
#(
  parameter int DW = 8,
  parameter int AW = 20
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          clr,
  input  logic [DW-1:0] a_in,
  input  logic [DW-1:0] b_in,
  output logic [DW-1:0] a_out,
  output logic [DW-1:0] b_out,
`ifdef SYSTOLIC_SAT_EN
  output logic          ovf,
`endif
  output logic [AW-1:0] acc
);

  logic [DW-1:0] a_q, a_d, b_q, b_d;
  logic [AW-1:0] acc_q, acc_d;
  logic signed [2*DW-1:0] a_ext, b_ext, prod;

  assign a_ext = {{DW{a_in[DW-1]}}, a_in};
  assign b_ext = {{DW{b_in[DW-1]}}, b_in};
  assign prod  = a_ext * b_ext;

`ifdef SYSTOLIC_SAT_EN
  logic  ovf_q, ovf_d;
  wide_t sum_w, sat_w;
  assign sum_w = sext(wide_t'(acc_q), AW) + wide_t'(prod);
  assign sat_w = sat_add(sext(wide_t'(acc_q), AW), wide_t'(prod), AW);
  assign ovf   = ovf_q;
`endif

  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    a_d   = a_q;
    b_d   = b_q;
    acc_d = acc_q;
`ifdef SYSTOLIC_SAT_EN
    ovf_d = ovf_q;
`endif
    if (clr) begin
      a_d   = '0;
      b_d   = '0;
      acc_d = '0;
`ifdef SYSTOLIC_SAT_EN
      ovf_d = 1'b0;
`endif
    end else if (en) begin
      a_d = a_in;
      b_d = b_in;
`ifdef SYSTOLIC_SAT_EN
      acc_d = AW'(sat_w);
      ovf_d = ovf_q | (sat_w != sum_w);
`else
      acc_d = AW'(sext(wide_t'(acc_q), AW) + wide_t'(prod));
`endif
    end
  end

  // NOTE: flops use non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q   <= '0;
      b_q   <= '0;
      acc_q <= '0;
`ifdef SYSTOLIC_SAT_EN
      ovf_q <= 1'b0;
`endif
    end else begin
      a_q   <= a_d;
      b_q   <= b_d;
      acc_q <= acc_d;
`ifdef SYSTOLIC_SAT_EN
      ovf_q <= ovf_d;
`endif
    end
  end

  assign a_out = a_q;
  assign b_out = b_q;
  assign acc   = acc_q;

endmodule

// File: rtl/systolic_mm_engine.sv
// Output-stationary ROWS x COLS systolic engine computing C = A x B with runtime K.
// Optional build macro SYSTOLIC_SAT_EN adds saturation and the ovf_flag output.
module systolic_mm_engine
  import systolic_pkg::*;
#(
  parameter int ROWS = 4,
  parameter int COLS = 4,
  parameter int DW   = 8,
  parameter int AW   = 20,
  parameter int KMAX = 64,
  parameter int KW   = $clog2(KMAX + 1),
  localparam int RW  = (ROWS > 1) ? $clog2(ROWS) : 1
) (
  input  logic               clk,
  input  logic               rstb,
  input  logic               start,
  input  logic [KW-1:0]      k_len,
  output logic               busy,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [ROWS*DW-1:0] in_a,
  input  logic [COLS*DW-1:0] in_b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [COLS*AW-1:0] out_data,
  output logic [RW-1:0]      out_row,
`ifdef SYSTOLIC_SAT_EN
  output logic               ovf_flag,
`endif
  output logic               out_last
);

  localparam int     FL         = flush_len(ROWS, COLS);
  localparam int     FCW        = $clog2(FL + 2);
  localparam state_t AFTER_LOAD = (FL > 0) ? ST_FLUSH : ST_DRAIN;

  state_t         state_q, state_d;
  logic [KW-1:0]  k_len_q, k_len_d, k_cnt_q, k_cnt_d, k_eff;
  logic [FCW-1:0] f_cnt_q, f_cnt_d;
  logic [RW-1:0]  row_q, row_d;
  logic           clr, step;

  logic [DW-1:0] a_op [ROWS];
  logic [DW-1:0] b_op [COLS];
  logic [DW-1:0] a_h  [ROWS][COLS+1];
  logic [DW-1:0] b_v  [ROWS+1][COLS];
  logic [AW-1:0] acc_w [ROWS][COLS];
`ifdef SYSTOLIC_SAT_EN
  logic          ovf_w [ROWS][COLS];
`endif

  assign k_eff = (k_len > KW'(KMAX)) ? KW'(KMAX) : k_len;
  assign step  = ((state_q == ST_LOAD) && in_valid) || (state_q == ST_FLUSH);

  // Operands are forced to zero outside LOAD so FLUSH pushes bubbles through the array.
  always_comb begin
    for (int i = 0; i < ROWS; i++) a_op[i] = (state_q == ST_LOAD) ? in_a[i*DW +: DW] : '0;
    for (int j = 0; j < COLS; j++) b_op[j] = (state_q == ST_LOAD) ? in_b[j*DW +: DW] : '0;
  end

  for (genvar i = 0; i < ROWS; i++) begin : g_skew_a
    if (i == 0) begin : g_direct
      assign a_h[i][0] = a_op[i];
    end else begin : g_delay
      logic [DW-1:0] sr_q [i];
      logic [DW-1:0] sr_d [i];
      always_comb begin
        sr_d = sr_q;
        if (clr) begin
          for (int n = 0; n < i; n++) sr_d[n] = '0;
        end else if (step) begin
          sr_d[0] = a_op[i];
          for (int n = 1; n < i; n++) sr_d[n] = sr_q[n-1];
        end
      end
      // NOTE: skew arrays are plain flops, not RAM, so they take the async reset too.
      always_ff @(posedge clk or posedge rstb) begin
        if (rstb) begin
          for (int n = 0; n < i; n++) sr_q[n] <= '0;
        end else begin
          sr_q <= sr_d;
        end
      end
      assign a_h[i][0] = sr_q[i-1];
    end
  end

  for (genvar j = 0; j < COLS; j++) begin : g_skew_b
    if (j == 0) begin : g_direct
      assign b_v[0][j] = b_op[j];
    end else begin : g_delay
      logic [DW-1:0] sr_q [j];
      logic [DW-1:0] sr_d [j];
      always_comb begin
        sr_d = sr_q;
        if (clr) begin
          for (int n = 0; n < j; n++) sr_d[n] = '0;
        end else if (step) begin
          sr_d[0] = b_op[j];
          for (int n = 1; n < j; n++) sr_d[n] = sr_q[n-1];
        end
      end
      always_ff @(posedge clk or posedge rstb) begin
        if (rstb) begin
          for (int n = 0; n < j; n++) sr_q[n] <= '0;
        end else begin
          sr_q <= sr_d;
        end
      end
      assign b_v[0][j] = sr_q[j-1];
    end
  end

  for (genvar i = 0; i < ROWS; i++) begin : g_row
    for (genvar j = 0; j < COLS; j++) begin : g_col
      systolic_pe #(.DW(DW), .AW(AW)) u_pe (
        .clk   (clk),
        .rst   (rstb),
        .en    (step),
        .clr   (clr),
        .a_in  (a_h[i][j]),
        .b_in  (b_v[i][j]),
        .a_out (a_h[i][j+1]),
        .b_out (b_v[i+1][j]),
`ifdef SYSTOLIC_SAT_EN
        .ovf   (ovf_w[i][j]),
`endif
        .acc   (acc_w[i][j])
      );
    end
  end

  always_comb begin
    state_d = state_q;
    k_len_d = k_len_q;
    k_cnt_d = k_cnt_q;
    f_cnt_d = f_cnt_q;
    row_d   = row_q;
    clr     = 1'b0;
    case (state_q)
      ST_IDLE: if (start) begin
        clr     = 1'b1;
        k_len_d = k_eff;
        k_cnt_d = '0;
        f_cnt_d = '0;
        row_d   = '0;
        state_d = (k_eff != '0) ? ST_LOAD : AFTER_LOAD;
      end
      ST_LOAD: if (in_valid) begin
        if (k_cnt_q == k_len_q - KW'(1)) state_d = AFTER_LOAD;
        else                             k_cnt_d = k_cnt_q + KW'(1);
      end
      ST_FLUSH: begin
        if (f_cnt_q == FCW'(FL - 1)) state_d = ST_DRAIN;
        else                         f_cnt_d = f_cnt_q + FCW'(1);
      end
      ST_DRAIN: if (out_ready) begin
        if (row_q == RW'(ROWS - 1)) begin
          state_d = ST_IDLE;
          row_d   = '0;
        end else begin
          row_d = row_q + RW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rstb) begin
    if (rstb) begin
      state_q <= ST_IDLE;
      k_len_q <= '0;
      k_cnt_q <= '0;
      f_cnt_q <= '0;
      row_q   <= '0;
    end else begin
      state_q <= state_d;
      k_len_q <= k_len_d;
      k_cnt_q <= k_cnt_d;
      f_cnt_q <= f_cnt_d;
      row_q   <= row_d;
    end
  end

  assign busy      = (state_q != ST_IDLE);
  assign in_ready  = (state_q == ST_LOAD);
  assign out_valid = (state_q == ST_DRAIN);
  assign out_row   = row_q;
  assign out_last  = out_valid && (row_q == RW'(ROWS - 1));

  always_comb begin
    out_data = '0;
    for (int j = 0; j < COLS; j++) out_data[j*AW +: AW] = acc_w[row_q][j];
  end

`ifdef SYSTOLIC_SAT_EN
  always_comb begin
    ovf_flag = 1'b0;
    for (int j = 0; j < COLS; j++) ovf_flag = ovf_flag | ovf_w[row_q][j];
    ovf_flag = ovf_flag & out_valid;
  end
`endif

endmodule

// File: tb/tb_systolic_mm_engine.sv
// Directed-plus-random bench for systolic_mm_engine against an integer matrix model.
// Build with or without SYSTOLIC_SAT_EN; an AW=16 instance covers overflow behaviour.
module tb_systolic_mm_engine;

  localparam int ROWS = 4;
  localparam int COLS = 4;
  localparam int DW   = 8;
  localparam int AW   = 20;
  localparam int AW16 = 16;
  localparam int KMAX = 64;
  localparam int KW   = 7;
  localparam int FL   = ROWS + COLS - 2;

  logic               clk = 1'b0;
  logic               rstb = 1'b1;
  logic               start = 1'b0;
  logic [KW-1:0]      k_len = '0;
  logic               in_valid = 1'b0;
  logic               out_ready = 1'b0;
  logic [ROWS*DW-1:0] in_a = '0;
  logic [COLS*DW-1:0] in_b = '0;

  logic                 busy, in_ready, out_valid, out_last;
  logic [COLS*AW-1:0]   out_data;
  logic [1:0]           out_row;
  logic                 busy16, in_ready16, out_valid16, out_last16;
  logic [COLS*AW16-1:0] out_data16;
  logic [1:0]           out_row16;
`ifdef SYSTOLIC_SAT_EN
  logic                 ovf_flag, ovf_flag16;
`endif

  int vectors = 0;
  int miscompares = 0;

  int     a_m [ROWS][KMAX];
  int     b_m [KMAX][COLS];
  longint exp_c [2][ROWS][COLS];
  bit     exp_ovf [2][ROWS];

  systolic_mm_engine #(.ROWS(ROWS), .COLS(COLS), .DW(DW), .AW(AW), .KMAX(KMAX), .KW(KW)) dut (
    .clk(clk), .rstb(rstb), .start(start), .k_len(k_len), .busy(busy),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_row(out_row),
`ifdef SYSTOLIC_SAT_EN
    .ovf_flag(ovf_flag),
`endif
    .out_last(out_last)
  );

  systolic_mm_engine #(.ROWS(ROWS), .COLS(COLS), .DW(DW), .AW(AW16), .KMAX(KMAX), .KW(KW)) dut16 (
    .clk(clk), .rstb(rstb), .start(start), .k_len(k_len), .busy(busy16),
    .in_valid(in_valid), .in_ready(in_ready16), .in_a(in_a), .in_b(in_b),
    .out_valid(out_valid16), .out_ready(out_ready), .out_data(out_data16), .out_row(out_row16),
`ifdef SYSTOLIC_SAT_EN
    .ovf_flag(ovf_flag16),
`endif
    .out_last(out_last16)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL timeout: observed no finish, required finish before 500000 ns");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Plain matrix product; saturation is applied per accumulate in k order, as the PE does.
  task automatic model(input int k);
    for (int w = 0; w < 2; w++) begin
      longint m;
      m = longint'(1) << ((w == 0) ? AW : AW16);
      for (int i = 0; i < ROWS; i++) begin
        exp_ovf[w][i] = 1'b0;
        for (int j = 0; j < COLS; j++) begin
          longint s;
          s = 0;
          for (int kk = 0; kk < k; kk++) begin
            s = s + a_m[i][kk] * b_m[kk][j];
`ifdef SYSTOLIC_SAT_EN
            if (s > m / 2 - 1) begin s = m / 2 - 1; exp_ovf[w][i] = 1'b1; end
            if (s < -(m / 2))  begin s = -(m / 2);  exp_ovf[w][i] = 1'b1; end
`else
            s = s % m;
            if (s >= m / 2)   s = s - m;
            if (s < -(m / 2)) s = s + m;
`endif
          end
          exp_c[w][i][j] = s;
        end
      end
    end
  endtask

  // mode 0: identity A, B[k][j]=k*4+j; 1: A=127, B=-128; 2: random; 3: A=B=127
  task automatic fill(input int mode);
    for (int kk = 0; kk < KMAX; kk++) begin
      for (int i = 0; i < ROWS; i++)
        case (mode)
          0:       a_m[i][kk] = (i == kk) ? 1 : 0;
          2:       a_m[i][kk] = int'($urandom_range(255)) - 128;
          default: a_m[i][kk] = 127;
        endcase
      for (int j = 0; j < COLS; j++)
        case (mode)
          0:       b_m[kk][j] = kk * 4 + j;
          1:       b_m[kk][j] = -128;
          2:       b_m[kk][j] = int'($urandom_range(255)) - 128;
          default: b_m[kk][j] = 127;
        endcase
    end
  endtask

  task automatic drive_beat(input int k);
    for (int i = 0; i < ROWS; i++) in_a[i*DW +: DW] = DW'(a_m[i][k]);
    for (int j = 0; j < COLS; j++) in_b[j*DW +: DW] = DW'(b_m[k][j]);
  endtask

  // Junk on inputs the DUT must ignore in the current phase.
  task automatic noise();
    start = 1'($urandom_range(1));
    k_len = KW'($urandom_range(127));
    in_a  = (ROWS*DW)'($urandom);
    in_b  = (COLS*DW)'($urandom);
  endtask

  task automatic run_job(input int k_req, input int gap_pct, input int stall_pct, input bit chk16);
    int  k, beat, cyc, fl_cyc, row;
    bit  v, r;
    k = (k_req > KMAX) ? KMAX : k_req;
    model(k);
    start = 1'b1; k_len = KW'(k_req); in_valid = 1'b0;
    tick();
    check("busy_after_start", busy, 1);
    beat = 0; cyc = 0;
    while (beat < k && cyc < 2000) begin
      check("in_ready_load", in_ready, 1);
      v = ($urandom_range(99) >= gap_pct);
      noise();
      in_valid = v;
      if (v) drive_beat(beat);
      tick();
      cyc++;
      if (v) beat++;
    end
    fl_cyc = 0;
    while (!out_valid && fl_cyc < 100) begin
      check("in_ready_flush", in_ready, 0);
      noise();
      in_valid = 1'b1;
      tick();
      fl_cyc++;
    end
    check("flush_cycles", fl_cyc, FL);
    row = 0; cyc = 0;
    while (row < ROWS && cyc < 400) begin
      check("out_valid_drain", out_valid, 1);
      check("busy_drain", busy, 1);
      check("out_row", out_row, row);
      check("out_last", out_last, (row == ROWS - 1) ? 1 : 0);
      for (int j = 0; j < COLS; j++)
        check($sformatf("out_data[%0d][%0d]", row, j), $signed(out_data[j*AW +: AW]), exp_c[0][row][j]);
`ifdef SYSTOLIC_SAT_EN
      check("ovf_flag", ovf_flag, exp_ovf[0][row]);
`endif
      if (chk16) begin
        for (int j = 0; j < COLS; j++)
          check($sformatf("out_data16[%0d][%0d]", row, j), $signed(out_data16[j*AW16 +: AW16]),
                exp_c[1][row][j]);
`ifdef SYSTOLIC_SAT_EN
        check("ovf_flag16", ovf_flag16, exp_ovf[1][row]);
`endif
      end
      r = ($urandom_range(99) >= stall_pct);
      noise();
      in_valid  = 1'($urandom_range(1));
      out_ready = r;
      tick();
      cyc++;
      if (r) row++;
    end
    start = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    check("busy_done", busy, 0);
    check("out_valid_done", out_valid, 0);
  endtask

  initial begin
    rstb = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_last", out_last, 0);
    check("rst_out_row", out_row, 0);
    check("rst_out_data_zero", (out_data === '0) ? 1 : 0, 1);
    rstb = 1'b0;
    tick();

    fill(0); run_job(4, 0, 0, 1'b0);
    fill(1); run_job(16, 0, 0, 1'b0);
    fill(2); run_job(8, 0, 0, 1'b0);
    run_job(8, 40, 50, 1'b0);
    repeat (3) begin
      fill(2); run_job(int'($urandom_range(12, 1)), 30, 40, 1'b0);
    end
    fill(2); run_job(0, 0, 30, 1'b0);
    fill(3); run_job(4, 0, 0, 1'b1);
    fill(2); run_job(100, 10, 20, 1'b0);

    // Abort a job during FLUSH, then make sure a fresh job starts clean.
    fill(2);
    start = 1'b1; k_len = KW'(5);
    tick();
    start = 1'b0;
    for (int b = 0; b < 5; b++) begin
      in_valid = 1'b1;
      drive_beat(b);
      tick();
    end
    in_valid = 1'b0;
    repeat (2) tick();
    rstb = 1'b1;
    tick();
    check("abort_busy", busy, 0);
    check("abort_out_valid", out_valid, 0);
    rstb = 1'b0;
    tick();
    fill(2); run_job(5, 20, 20, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
